// File: rtl/conv2d_kxk_stream.sv
// Streaming KxK 2-D convolution: line-buffered window, streamed kernel, signed MAC with
// shift/ReLU/saturation, one output beat per filter group and tlast on the image's final beat.
module conv2d_kxk_stream #(
    parameter int unsigned IN_HEIGHT       = 5,
    parameter int unsigned IN_WIDTH        = 5,
    parameter int unsigned IN_CHANNEL      = 2,
    parameter int unsigned WORD_WIDTH      = 8,
    parameter int unsigned KSIZE           = 3,
    parameter int unsigned STRIDE          = 1,
    parameter int unsigned FILTERS         = 4,
    parameter int unsigned FILTER_PER_LINE = 2,
    parameter int unsigned ACC_WIDTH       = 24,
    parameter int unsigned OUT_SHIFT       = 0
) (
    input  logic                                          i_aclk,
    input  logic                                          i_aresetn,
    input  logic                                          i_tvalid,
    output logic                                          o_tready,
    input  logic [IN_CHANNEL*WORD_WIDTH-1:0]              i_tdata,
    input  logic                                          i_kernel_tvalid,
    output logic                                          o_kernel_tready,
    input  logic [FILTER_PER_LINE*IN_CHANNEL*WORD_WIDTH-1:0] i_kernel_tdata,
    input  logic                                          i_relu,
    output logic                                          o_tvalid,
    input  logic                                          i_tready,
    output logic [FILTER_PER_LINE*WORD_WIDTH-1:0]         o_tdata,
    output logic                                          o_tlast,
    output logic                                          o_kernel_valid
);

    localparam int unsigned GROUPS       = FILTERS / FILTER_PER_LINE;
    localparam int unsigned KK           = KSIZE * KSIZE;
    localparam int unsigned KERNEL_BEATS = GROUPS * KK;
    localparam int unsigned PIX_W        = IN_CHANNEL * WORD_WIDTH;
    localparam int unsigned KBEAT_W      = FILTER_PER_LINE * PIX_W;
    localparam int unsigned OUT_H        = (IN_HEIGHT - KSIZE) / STRIDE + 1;
    localparam int unsigned OUT_W        = (IN_WIDTH - KSIZE) / STRIDE + 1;
    localparam int unsigned LAST_ROW     = KSIZE - 1 + (OUT_H - 1) * STRIDE;
    localparam int unsigned LAST_COL     = KSIZE - 1 + (OUT_W - 1) * STRIDE;
    localparam int unsigned RW           = (IN_HEIGHT > 1) ? $clog2(IN_HEIGHT) : 1;
    localparam int unsigned CW           = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
    localparam int unsigned GW           = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int unsigned KBW          = (KERNEL_BEATS > 1) ? $clog2(KERNEL_BEATS) : 1;
    localparam int unsigned LB_ROWS      = (KSIZE > 1) ? KSIZE - 1 : 1;

    localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
        {{(ACC_WIDTH-WORD_WIDTH+1){1'b0}}, {(WORD_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {StKLoad, StRun, StEmit} state_t;

    state_t          state;
    logic [RW-1:0]   row;
    logic [CW-1:0]   col;
    logic [GW-1:0]   group;
    logic [KBW-1:0]  kcnt;
    logic            pix_last;

    logic [PIX_W-1:0]   line_buf [LB_ROWS][IN_WIDTH];
    logic [PIX_W-1:0]   window   [KSIZE][KSIZE];
    logic [PIX_W-1:0]   col_in   [KSIZE];
    logic [KBEAT_W-1:0] kmem     [KERNEL_BEATS];

    logic frame_start, kernel_hs, pix_hs;
    logic col_last, row_last, row_ok, col_ok, emit_pos, is_last_pix;

    assign frame_start = (row == '0) && (col == '0);
    assign kernel_hs   = i_kernel_tvalid && o_kernel_tready;
    // A pending kernel at frame start wins over pixels, so ready must drop in the same cycle.
    assign o_tready    = (state == StRun) && !(frame_start && i_kernel_tvalid);
    assign pix_hs      = i_tvalid && o_tready;
    assign col_last    = (col == CW'(IN_WIDTH - 1));
    assign row_last    = (row == RW'(IN_HEIGHT - 1));
    assign is_last_pix = (row == RW'(LAST_ROW)) && (col == CW'(LAST_COL));

    always_comb begin
        row_ok   = (32'(row) >= KSIZE - 1) && (((32'(row) - (KSIZE - 1)) % STRIDE) == 0);
        col_ok   = (32'(col) >= KSIZE - 1) && (((32'(col) - (KSIZE - 1)) % STRIDE) == 0);
        emit_pos = row_ok && col_ok;
    end

    // Column entering the window: buffered rows above, live pixel at the bottom.
    always_comb begin
        for (int ky = 0; ky < KSIZE; ky++) col_in[ky] = i_tdata;
        for (int ky = 0; ky < KSIZE - 1; ky++) col_in[ky] = line_buf[ky][col];
    end

    always_ff @(posedge i_aclk) begin
        if (pix_hs) begin
            for (int ky = 0; ky < KSIZE; ky++) begin
                for (int kx = 0; kx < KSIZE - 1; kx++) window[ky][kx] <= window[ky][kx+1];
                window[ky][KSIZE-1] <= col_in[ky];
            end
            for (int r = 0; r < KSIZE - 1; r++) line_buf[r][col] <= col_in[r+1];
        end
        if (kernel_hs) kmem[kcnt] <= i_kernel_tdata;
    end

    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state           <= StKLoad;
            row             <= '0;
            col             <= '0;
            group           <= '0;
            kcnt            <= '0;
            pix_last        <= 1'b0;
            o_tvalid        <= 1'b0;
            o_tlast         <= 1'b0;
            o_kernel_tready <= 1'b1;
            o_kernel_valid  <= 1'b0;
        end else begin
            unique case (state)
                StKLoad: begin
                    if (kernel_hs) begin
                        if (kcnt == KBW'(KERNEL_BEATS - 1)) begin
                            kcnt            <= '0;
                            o_kernel_tready <= 1'b0;
                            o_kernel_valid  <= 1'b1;
                            state           <= StRun;
                        end else begin
                            kcnt <= kcnt + 1'b1;
                        end
                    end
                end
                StRun: begin
                    if (frame_start && i_kernel_tvalid) begin
                        state           <= StKLoad;
                        o_kernel_valid  <= 1'b0;
                        o_kernel_tready <= 1'b1;
                        kcnt            <= '0;
                    end else if (pix_hs) begin
                        col <= col_last ? '0 : col + 1'b1;
                        if (col_last) row <= row_last ? '0 : row + 1'b1;
                        if (emit_pos) begin
                            state    <= StEmit;
                            group    <= '0;
                            o_tvalid <= 1'b1;
                            pix_last <= is_last_pix;
                            o_tlast  <= is_last_pix && (GROUPS == 1);
                        end
                    end
                end
                StEmit: begin
                    if (i_tready) begin
                        if (group == GW'(GROUPS - 1)) begin
                            state    <= StRun;
                            group    <= '0;
                            o_tvalid <= 1'b0;
                            o_tlast  <= 1'b0;
                        end else begin
                            group   <= group + 1'b1;
                            o_tlast <= pix_last && (32'(group) + 1 == GROUPS - 1);
                        end
                    end
                end
                default: state <= StKLoad;
            endcase
        end
    end

    always_comb begin
        logic signed [ACC_WIDTH-1:0]  acc, px, wt, shifted;
        logic signed [WORD_WIDTH-1:0] w_px, w_wt;
        logic [KBEAT_W-1:0]           kb;
        logic [KBW-1:0]               kidx;
        o_tdata = '0;
        acc     = '0;
        px      = '0;
        wt      = '0;
        shifted = '0;
        w_px    = '0;
        w_wt    = '0;
        kb      = '0;
        kidx    = '0;
        for (int f = 0; f < FILTER_PER_LINE; f++) begin
            acc = '0;
            for (int ky = 0; ky < KSIZE; ky++) begin
                for (int kx = 0; kx < KSIZE; kx++) begin
                    kidx = KBW'(32'(group) * KK + 32'(ky) * KSIZE + 32'(kx));
                    kb   = kmem[kidx];
                    for (int c = 0; c < IN_CHANNEL; c++) begin
                        w_px = window[ky][kx][c*WORD_WIDTH +: WORD_WIDTH];
                        w_wt = kb[(f*IN_CHANNEL+c)*WORD_WIDTH +: WORD_WIDTH];
                        px   = ACC_WIDTH'(w_px);
                        wt   = ACC_WIDTH'(w_wt);
                        acc  = acc + px * wt;
                    end
                end
            end
            shifted = acc >>> OUT_SHIFT;
            if (i_relu && (shifted < 0)) shifted = '0;
            if (shifted > SAT_MAX) begin
                o_tdata[f*WORD_WIDTH +: WORD_WIDTH] = SAT_MAX[WORD_WIDTH-1:0];
            end else if (shifted < SAT_MIN) begin
                o_tdata[f*WORD_WIDTH +: WORD_WIDTH] = SAT_MIN[WORD_WIDTH-1:0];
            end else begin
                o_tdata[f*WORD_WIDTH +: WORD_WIDTH] = shifted[WORD_WIDTH-1:0];
            end
        end
    end

endmodule
